// File: rtl/wave_delay_player_pkg.sv
// Shared definitions for the wave delay player.
// Holds the FSM state encoding and the address/delay width defaults that the
// UART receive path also uses when it fills the per-channel delay RAMs.
package wave_delay_player_pkg;

    localparam int WDP_ADDR_W  = 11;
    localparam int WDP_DELAY_W = 24;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_COUNT = 3'd2,
        ST_PULSE = 3'd3,
        ST_DONE  = 3'd4
    } wdp_state_t;

endpackage

// File: rtl/wave_delay_player_counter.sv
// Loadable down-counter with terminal-count flags.
// Ports:
//   i_clk       clock
//   i_rst       asynchronous reset, active-high (clears count)
//   i_load      load i_load_val (has priority over i_en)
//   i_load_val  value to load
//   i_en        decrement by one; holds at zero, so it never underflows
//   o_zero      count == 0
//   o_one       count == 1
module wave_delay_player_counter #(
    parameter int W = 24
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero,
    output logic         o_one
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - W'(1);
        end
    end

    assign o_zero = (r_count == '0);
    assign o_one  = (r_count == W'(1));

endmodule

// File: rtl/wave_delay_player.sv
// Wave delay player: on a trigger, reads the delay word stored at the wave ID
// from the delay RAM, counts it down in 10 MHz ticks, then emits a fixed-width
// pulse. Owns only the RAM read port.
//
//   state  | meaning
//   IDLE   | waiting for I_trig; address latched and RAM read issued on accept
//   FETCH  | waiting RAM_RD_LAT cycles; delay captured on the last one
//   COUNT  | delay counter running down to 1
//   PULSE  | O_pulse high for PULSE_W cycles
//   DONE   | O_done strobe, back to IDLE
//
// Ports:
//   I_clk_10M   10 MHz system clock
//   I_rst       asynchronous reset, active-high (released synchronously inside)
//   I_trig      start strobe, accepted only in IDLE
//   I_wave_id   wave ID / RAM address, sampled with an accepted trigger
//   I_abort     cancel playback (ignored in IDLE)
//   O_RAM_ADDR  RAM read address, holds last accepted ID
//   O_RAM_EN    RAM read enable, one cycle per accepted trigger
//   I_RAM_DOUT  RAM read data (delay word)
//   O_pulse     delayed output pulse
//   O_busy      high whenever not IDLE
//   O_done      one-cycle strobe at normal completion
//   O_err       one-cycle strobe when a trigger arrives while busy
module wave_delay_player
    import wave_delay_player_pkg::*;
#(
    parameter int ADDR_W     = WDP_ADDR_W,
    parameter int DELAY_W    = WDP_DELAY_W,
    parameter int RAM_RD_LAT = 2,
    parameter int PULSE_W    = 10
) (
    input  logic               I_clk_10M,
    input  logic               I_rst,
    input  logic               I_trig,
    input  logic [ADDR_W-1:0]  I_wave_id,
    input  logic               I_abort,
    output logic [ADDR_W-1:0]  O_RAM_ADDR,
    output logic               O_RAM_EN,
    input  logic [DELAY_W-1:0] I_RAM_DOUT,
    output logic               O_pulse,
    output logic               O_busy,
    output logic               O_done,
    output logic               O_err
);

    localparam int         PW_W       = $clog2(PULSE_W + 1);
    localparam logic [2:0] FETCH_LAST = 3'(RAM_RD_LAT - 1);

    logic [1:0]        r_rst_sync;
    logic              w_rst;
    wdp_state_t        r_state;
    logic [2:0]        r_fetch_cnt;
    logic              r_pulse;
    logic              r_done;
    logic              r_err;
    logic              r_ram_en;
    logic [ADDR_W-1:0] r_ram_addr;

    logic w_fetch_last;
    logic w_dout_zero;
    logic w_dly_zero;
    logic w_dly_one;
    logic w_pls_zero;
    logic w_pls_one;
    logic w_count_end;
    logic w_pulse_end;
    logic w_pls_load;

    // Reset asserts immediately, releases two clocks after I_rst falls.
    always_ff @(posedge I_clk_10M or posedge I_rst) begin
        if (I_rst) begin
            r_rst_sync <= 2'b11;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b0};
        end
    end
    assign w_rst = r_rst_sync[1];

    assign w_fetch_last = (r_state == ST_FETCH) && (r_fetch_cnt == FETCH_LAST);
    assign w_dout_zero  = (I_RAM_DOUT == '0);
    // Zero flags are only a guard; the normal exit is at count==1.
    assign w_count_end  = w_dly_one || w_dly_zero;
    assign w_pulse_end  = w_pls_one || w_pls_zero;
    assign w_pls_load   = (w_fetch_last && w_dout_zero) ||
                          ((r_state == ST_COUNT) && w_count_end);

    wave_delay_player_counter #(.W(DELAY_W)) u_dly_cnt (
        .i_clk      (I_clk_10M),
        .i_rst      (w_rst),
        .i_load     (w_fetch_last),
        .i_load_val (I_RAM_DOUT),
        .i_en       (r_state == ST_COUNT),
        .o_zero     (w_dly_zero),
        .o_one      (w_dly_one)
    );

    wave_delay_player_counter #(.W(PW_W)) u_pls_cnt (
        .i_clk      (I_clk_10M),
        .i_rst      (w_rst),
        .i_load     (w_pls_load),
        .i_load_val (PW_W'(PULSE_W)),
        .i_en       (r_state == ST_PULSE),
        .o_zero     (w_pls_zero),
        .o_one      (w_pls_one)
    );

    always_ff @(posedge I_clk_10M or posedge w_rst) begin
        if (w_rst) begin
            r_state     <= ST_IDLE;
            r_fetch_cnt <= '0;
            r_pulse     <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_ram_en    <= 1'b0;
            r_ram_addr  <= '0;
        end else begin
            r_done   <= 1'b0;
            r_ram_en <= 1'b0;
            r_err    <= I_trig && (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (I_trig) begin
                        r_ram_addr  <= I_wave_id;
                        r_ram_en    <= 1'b1;
                        r_fetch_cnt <= '0;
                        r_state     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (I_abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_fetch_last) begin
                        // A zero delay skips COUNT so the pulse follows the fetch directly.
                        if (w_dout_zero) begin
                            r_pulse <= 1'b1;
                            r_state <= ST_PULSE;
                        end else begin
                            r_state <= ST_COUNT;
                        end
                    end else begin
                        r_fetch_cnt <= r_fetch_cnt + 3'd1;
                    end
                end
                ST_COUNT: begin
                    if (I_abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_count_end) begin
                        r_pulse <= 1'b1;
                        r_state <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (I_abort) begin
                        r_pulse <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_pulse_end) begin
                        r_pulse <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_pulse <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign O_RAM_ADDR = r_ram_addr;
    assign O_RAM_EN   = r_ram_en;
    assign O_pulse    = r_pulse;
    assign O_busy     = (r_state != ST_IDLE);
    assign O_done     = r_done;
    assign O_err      = r_err;

endmodule
